// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants and FSM state encoding for the interrupt
//               controller and the core's dispatch logic.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int          IRQ_MAX            = 16;
    localparam int          IRQ_ID_W           = $clog2(IRQ_MAX);
    localparam logic [15:0] VEC_BASE_DEFAULT   = 16'h0040;
    localparam int          VEC_STRIDE_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Lowest-index-first priority encoder with a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0]    req,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] idx
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IRQ_ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : NUM_IRQ-channel interrupt controller: edge detect, IE/IF
//               registers, fixed-priority vectoring and a four-phase
//               req/ack handshake. IRQ_CTRL_NESTED_EN adds an in-service mask.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic               ie_wr,
    input  logic               if_wr,
    input  logic [NUM_IRQ-1:0] wdata,
    output logic [NUM_IRQ-1:0] int_en,
    output logic [NUM_IRQ-1:0] int_flags,
    output logic               irq_req,
    output logic [15:0]        irq_vec,
    output logic [3:0]         irq_id,
    input  logic               irq_ack,
    output logic               pending
`ifdef IRQ_CTRL_NESTED_EN
    ,
    input  logic               irq_done
`endif
);

    irq_state_e         r_state, w_state_n;
    logic [NUM_IRQ-1:0] r_src_q;
    logic               r_armed;
    logic [NUM_IRQ-1:0] w_rise, w_en_n, w_flags_n, w_id_mask, w_ack_clr;
    logic               w_sel_valid, w_grant_ok;
    logic [3:0]         w_sel;
    logic [15:0]        w_vec;
    logic               w_req_n;
    logic [3:0]         w_id_n;
    logic [15:0]        w_vec_n;

    // r_armed masks the first cycle after reset so a source already high
    // while in reset only loads the history instead of firing.
    assign w_rise  = r_armed ? (irq_src & ~r_src_q) : '0;
    assign pending = |(int_en & int_flags);

    irq_prio_enc #(.WIDTH(NUM_IRQ)) u_sel_enc (
        .req   (int_en & int_flags),
        .valid (w_sel_valid),
        .idx   (w_sel)
    );

    assign w_vec = VEC_BASE + 16'(w_sel) * 16'(VEC_STRIDE);

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_id_mask[i] = (irq_id == 4'(i));
        end
    end

    assign w_ack_clr = (r_state == REQ && irq_ack) ? w_id_mask : '0;
    assign w_en_n    = ie_wr ? wdata : int_en;
    assign w_flags_n = ((if_wr ? wdata : int_flags) & ~w_ack_clr) | w_rise;

`ifdef IRQ_CTRL_NESTED_EN
    logic [NUM_IRQ-1:0] r_isr, w_isr_clr;
    logic               w_isr_valid;
    logic [3:0]         w_isr_idx;

    irq_prio_enc #(.WIDTH(NUM_IRQ)) u_isr_enc (
        .req   (r_isr),
        .valid (w_isr_valid),
        .idx   (w_isr_idx)
    );

    assign w_grant_ok = !w_isr_valid || (w_sel < w_isr_idx);

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_isr_clr[i] = irq_done && w_isr_valid && (w_isr_idx == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_isr <= '0;
        end else begin
            r_isr <= (r_isr & ~w_isr_clr) | w_ack_clr;
        end
    end
`else
    assign w_grant_ok = 1'b1;
`endif

    always_comb begin
        w_state_n = r_state;
        w_req_n   = irq_req;
        w_id_n    = irq_id;
        w_vec_n   = irq_vec;
        case (r_state)
            IDLE: begin
                if (w_sel_valid && w_grant_ok) begin
                    w_state_n = REQ;
                    w_req_n   = 1'b1;
                    w_id_n    = w_sel;
                    w_vec_n   = w_vec;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    w_state_n = WAIT;
                    w_req_n   = 1'b0;
                end else if (!(|(w_en_n & w_flags_n & w_id_mask))) begin
                    // Software removed the granted source: withdraw.
                    w_state_n = IDLE;
                    w_req_n   = 1'b0;
                end
            end
            WAIT: begin
                if (!irq_ack) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_src_q   <= '0;
            r_armed   <= 1'b0;
            int_en    <= '0;
            int_flags <= '0;
            irq_req   <= 1'b0;
            irq_id    <= '0;
            irq_vec   <= '0;
        end else begin
            r_state   <= w_state_n;
            r_src_q   <= irq_src;
            r_armed   <= 1'b1;
            int_en    <= w_en_n;
            int_flags <= w_flags_n;
            irq_req   <= w_req_n;
            irq_id    <= w_id_n;
            irq_vec   <= w_vec_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl (NUM_IRQ=5).
//               Nested scenario is built only with IRQ_CTRL_NESTED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] irq_src, wdata, int_en, int_flags;
    logic       ie_wr, if_wr, irq_req, irq_ack, pending;
    logic [15:0] irq_vec;
    logic [3:0] irq_id;
`ifdef IRQ_CTRL_NESTED_EN
    logic       irq_done;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(5), .VEC_BASE(16'h0040), .VEC_STRIDE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .ie_wr     (ie_wr),
        .if_wr     (if_wr),
        .wdata     (wdata),
        .int_en    (int_en),
        .int_flags (int_flags),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .pending   (pending)
`ifdef IRQ_CTRL_NESTED_EN
        ,
        .irq_done  (irq_done)
`endif
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_cycle();
        irq_ack = 1'b1; tick();
        irq_ack = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_src = 5'b00001; ie_wr = 1'b0; if_wr = 1'b0;
        wdata = '0; irq_ack = 1'b0;
`ifdef IRQ_CTRL_NESTED_EN
        irq_done = 1'b0;
`endif
        tick(3);
        checks++; if ({int_en, int_flags} !== 10'b0) begin failures++; $display("FAIL reset_regs got en=%b if=%b exp 0/0", int_en, int_flags); end
        checks++; if ({irq_req, irq_vec, irq_id, pending} !== 22'b0) begin failures++; $display("FAIL reset_outs got req=%b vec=%h id=%0d pend=%b exp all 0", irq_req, irq_vec, irq_id, pending); end
        rst = 1'b1;
        tick(3);
        checks++; if (int_flags !== 5'b00000 || irq_req !== 1'b0) begin failures++; $display("FAIL held_src got if=%b req=%b exp 00000/0", int_flags, irq_req); end
        irq_src = 5'b00000; tick();
        irq_src = 5'b00001; tick();
        checks++; if (int_flags !== 5'b00001) begin failures++; $display("FAIL first_edge got if=%b exp 00001", int_flags); end
        irq_src = '0; if_wr = 1'b1; wdata = '0; tick();
        if_wr = 1'b0;
    endtask

    task automatic test_priority();
        ie_wr = 1'b1; wdata = 5'b11111; tick();
        ie_wr = 1'b0; wdata = '0; irq_src = 5'b00101; tick();
        irq_src = '0;
        checks++; if (int_flags !== 5'b00101 || irq_req !== 1'b0) begin failures++; $display("FAIL prio_flags got if=%b req=%b exp 00101/0", int_flags, irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd0 || irq_vec !== 16'h0040) begin failures++; $display("FAIL prio_grant0 got req=%b id=%0d vec=%h exp 1/0/0040", irq_req, irq_id, irq_vec); end
        irq_ack = 1'b1; tick();
        checks++; if (irq_req !== 1'b0 || int_flags !== 5'b00100) begin failures++; $display("FAIL prio_ack0 got req=%b if=%b exp 0/00100", irq_req, int_flags); end
        irq_ack = 1'b0; tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL prio_gap got req=%b exp 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd2 || irq_vec !== 16'h0050) begin failures++; $display("FAIL prio_grant2 got req=%b id=%0d vec=%h exp 1/2/0050", irq_req, irq_id, irq_vec); end
        ack_cycle();
        checks++; if (int_flags !== 5'b00000 || irq_req !== 1'b0) begin failures++; $display("FAIL prio_done got if=%b req=%b exp 00000/0", int_flags, irq_req); end
    endtask

    task automatic test_withdraw();
        ie_wr = 1'b1; wdata = 5'b00100; tick();
        ie_wr = 1'b0; irq_src = 5'b00100; tick();
        irq_src = '0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd2) begin failures++; $display("FAIL wd_req got req=%b id=%0d exp 1/2", irq_req, irq_id); end
        ie_wr = 1'b1; wdata = '0; tick();
        ie_wr = 1'b0;
        checks++; if (irq_req !== 1'b0 || int_flags !== 5'b00100) begin failures++; $display("FAIL wd_drop got req=%b if=%b exp 0/00100", irq_req, int_flags); end
        tick();
        checks++; if (irq_req !== 1'b0 || pending !== 1'b0) begin failures++; $display("FAIL wd_idle got req=%b pend=%b exp 0/0", irq_req, pending); end
        ie_wr = 1'b1; wdata = 5'b00100; tick();
        ie_wr = 1'b0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd2) begin failures++; $display("FAIL wd_rereq got req=%b id=%0d exp 1/2", irq_req, irq_id); end
        ack_cycle();
    endtask

    task automatic test_if_write_rise();
        if_wr = 1'b1; wdata = 5'b00011; tick();
        checks++; if (int_flags !== 5'b00011) begin failures++; $display("FAIL ifw_load got if=%b exp 00011", int_flags); end
        wdata = 5'b00000; irq_src = 5'b01000; tick();
        if_wr = 1'b0; irq_src = '0;
        checks++; if (int_flags !== 5'b01000 || irq_req !== 1'b0) begin failures++; $display("FAIL ifw_rise got if=%b req=%b exp 01000/0", int_flags, irq_req); end
        if_wr = 1'b1; wdata = '0; tick();
        if_wr = 1'b0;
    endtask

    task automatic test_ack_precedence();
        if_wr = 1'b1; wdata = 5'b00100; tick();
        if_wr = 1'b0; tick();
        checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL ap_req1 got req=%b exp 1", irq_req); end
        irq_ack = 1'b1; if_wr = 1'b1; wdata = 5'b00100; tick();
        checks++; if (int_flags !== 5'b00000 || irq_req !== 1'b0) begin failures++; $display("FAIL ap_ack_beats_wr got if=%b req=%b exp 00000/0", int_flags, irq_req); end
        irq_ack = 1'b0; if_wr = 1'b0; tick(2);
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL ap_quiet got req=%b exp 0", irq_req); end
        if_wr = 1'b1; wdata = 5'b00100; tick();
        if_wr = 1'b0; tick();
        irq_ack = 1'b1; irq_src = 5'b00100; tick();
        checks++; if (int_flags !== 5'b00100) begin failures++; $display("FAIL ap_rise_beats_ack got if=%b exp 00100", int_flags); end
        irq_ack = 1'b0; irq_src = '0; tick(2);
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd2) begin failures++; $display("FAIL ap_rereq got req=%b id=%0d exp 1/2", irq_req, irq_id); end
        ack_cycle();
    endtask

    task automatic test_ack_hold();
        ie_wr = 1'b1; wdata = 5'b00111; tick();
        ie_wr = 1'b0; if_wr = 1'b1; wdata = 5'b00011; tick();
        if_wr = 1'b0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd0) begin failures++; $display("FAIL hold_req0 got req=%b id=%0d exp 1/0", irq_req, irq_id); end
        irq_ack = 1'b1; tick();
        checks++; if (irq_req !== 1'b0 || int_flags !== 5'b00010) begin failures++; $display("FAIL hold_ack got req=%b if=%b exp 0/00010", irq_req, int_flags); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL hold_wait%0d got req=%b exp 0", k, irq_req); end
        end
        irq_ack = 1'b0; tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL hold_release got req=%b exp 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd1 || irq_vec !== 16'h0048) begin failures++; $display("FAIL hold_req1 got req=%b id=%0d vec=%h exp 1/1/0048", irq_req, irq_id, irq_vec); end
        ack_cycle();
    endtask

    task automatic test_reset_mid();
        if_wr = 1'b1; wdata = 5'b00100; tick();
        if_wr = 1'b0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd2) begin failures++; $display("FAIL rm_req got req=%b id=%0d exp 1/2", irq_req, irq_id); end
        rst = 1'b0; #1;
        checks++; if (irq_req !== 1'b0 || int_flags !== 5'b0 || int_en !== 5'b0) begin failures++; $display("FAIL rm_async got req=%b if=%b en=%b exp 0/00000/00000", irq_req, int_flags, int_en); end
        tick();
        rst = 1'b1; tick(2);
        checks++; if (irq_req !== 1'b0 || pending !== 1'b0) begin failures++; $display("FAIL rm_after got req=%b pend=%b exp 0/0", irq_req, pending); end
    endtask

`ifdef IRQ_CTRL_NESTED_EN
    task automatic test_nested();
        ie_wr = 1'b1; wdata = 5'b11111; tick();
        ie_wr = 1'b0; if_wr = 1'b1; wdata = 5'b01000; tick();
        if_wr = 1'b0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd3) begin failures++; $display("FAIL nest_req3 got req=%b id=%0d exp 1/3", irq_req, irq_id); end
        ack_cycle();
        if_wr = 1'b1; wdata = 5'b10000; tick();
        if_wr = 1'b0; tick(2);
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL nest_block4 got req=%b exp 0", irq_req); end
        if_wr = 1'b1; wdata = 5'b10010; tick();
        if_wr = 1'b0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd1) begin failures++; $display("FAIL nest_req1 got req=%b id=%0d exp 1/1", irq_req, irq_id); end
        ack_cycle();
        irq_done = 1'b1; tick();
        irq_done = 1'b0; tick();
        checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL nest_still_blocked got req=%b exp 0", irq_req); end
        irq_done = 1'b1; tick();
        irq_done = 1'b0; tick();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd4 || irq_vec !== 16'h0060) begin failures++; $display("FAIL nest_req4 got req=%b id=%0d vec=%h exp 1/4/0060", irq_req, irq_id, irq_vec); end
        ack_cycle();
        irq_done = 1'b1; tick();
        irq_done = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_withdraw();
        test_if_write_rise();
        test_ack_precedence();
        test_ack_hold();
        test_reset_mid();
`ifdef IRQ_CTRL_NESTED_EN
        test_nested();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
